mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multicycle signed multiply/divide unit for the datapath. It sits directly downstream of the ALU operand-select muxes: it takes the A-side operand and the B-side operand produced by the ALU-B mux path and runs a 32-iteration shift/add (Booth radix-2) multiply or a restoring divide. It leaves the result in HI/LO for the `mfhi`/`mflo` path. The control unit FSM starts it and waits on `done`.

## Interface
- No parameters; datapath width is fixed at 32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low. `reset = 0` at a rising edge clears the block.
- `operand_a` in 32: dividend or multiplicand, two's complement.
- `operand_b` in 32: divisor or multiplier, from the ALU-B mux output.
- `start_mult` in 1: request a signed multiply; sampled only in IDLE.
- `start_div` in 1: request a signed divide; sampled only in IDLE.
- `hi` out 32: multiply gives product[63:32]; divide gives the remainder.
- `lo` out 32: multiply gives product[31:0]; divide gives the quotient.
- `busy` out 1: high while an operation is in progress (RUN state).
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid from this cycle on.
- `div_zero` out 1: one-cycle pulse with `done` when a divide had divisor 0.

## Operation
- States and transitions:
  - IDLE: `start_mult`/`start_div` seen → latch `operand_a`/`operand_b` and the op type → RUN. Counter is set to 0.
  - RUN: one iteration per cycle, counter 0..31. After iteration 31 → FIN.
  - FIN: write `hi`/`lo`, pulse `done` → IDLE.
  - ZDIV: entered from IDLE on `start_div` with `operand_b == 0`. Pulses `done` and `div_zero` → IDLE. `hi`/`lo` are unchanged.
- Multiply: Booth radix-2 on a 65-bit {A, Q, Q-1} register with an arithmetic right shift each iteration. The result is the full 64-bit signed product. No overflow is possible.
- Divide: operands are converted to magnitudes, then a 32-step restoring division runs. Sign fix-ups are applied in FIN:
  - Quotient sign = sign(a) XOR sign(b); quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide `0x80000000 / 0xFFFFFFFF` gives `lo = 0x80000000`, `hi = 0`. No flag is raised.
- Simultaneous `start_mult` and `start_div` in IDLE: multiply wins, the divide request is dropped.
- Any start while in RUN, FIN or ZDIV is ignored; there is no queuing.
- Operands are latched at start. Input changes during RUN have no effect.
- `hi`/`lo` hold their last value until the next FIN. An aborted op never updates them.

## Timing
- Reset values: state IDLE, `hi = 0`, `lo = 0`, `busy = 0`, `done = 0`, `div_zero = 0`, counter 0.
- Start is sampled at edge E0. `busy` is high from after E0 through the end of the last RUN cycle.
- Iterations occur at E1..E32. `done` is high in the cycle after E33, i.e. 33 cycles after the start edge, for exactly one cycle. `busy` is 0 during that cycle.
- Divide by zero: `done` and `div_zero` are high in the cycle after E1, for one cycle. `busy` never rises.
- A new start is accepted at the edge that ends the `done` cycle, so the minimum op-to-op spacing is 34 cycles.
- `reset = 0` mid-operation: at that edge the unit returns to IDLE and clears `hi`/`lo`. No `done` is produced.

## Configuration
- `MULT_DIV_DIVIDER_EN` defined: full behaviour as above, including the divider datapath, the sign fix-up logic and ZDIV.
- `MULT_DIV_DIVIDER_EN` not defined:
  - The divider datapath is removed.
  - `start_div` alone in IDLE goes to ZDIV regardless of `operand_b`: `done` and `div_zero` pulse one cycle later, `hi`/`lo` unchanged. The control unit can raise an exception from this.
  - Multiply behaviour and timing are unchanged.

## Test plan
- Multiply 7 × −3 (`0x00000007`, `0xFFFFFFFD`) → `hi = 0xFFFFFFFF`, `lo = 0xFFFFFFEB`; `done` exactly 33 cycles after the start edge.
- Multiply `0x80000000 × 0x80000000` → `hi = 0x40000000`, `lo = 0x00000000`.
- Divide −7 / 2 → `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`. Divide `0x80000000 / 0xFFFFFFFF` → `lo = 0x80000000`, `hi = 0`, `div_zero = 0`.
- Divide 5 / 0 with prior `hi`/`lo` = 1/2 → `done` and `div_zero` in the cycle after the start edge; `hi = 1`, `lo = 2`; `busy` stays 0. Without the macro, any `start_div` gives the same response.
- Reset and start rules:
  - `reset = 0` at cycle 10 of a multiply → IDLE, `hi`/`lo = 0`, no `done` pulse.
  - `start_div` pulsed at cycle 5 of a multiply → ignored; a single `done` arrives at cycle 33.
  - `start_mult` and `start_div` asserted together → the multiply result is produced.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed 32x32 multiply (Booth radix-2) and
// restoring divide. Results land in HI/LO for the mfhi/mflo path.
// Optional feature macro: MULT_DIV_DIVIDER_EN. When it is defined, the
// divider datapath is built. When it is undefined, every start_div request
// is answered through ZDIV (done + div_zero, HI/LO untouched).
// Handshake: a start is taken only in IDLE. done pulses for one cycle and
// hi/lo are valid from that cycle on. Starts seen outside IDLE are dropped.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        start_mult,
  input  logic        start_div,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_ZDIV} state_t;

  state_t      state_q, state_d;
  // acc is one bit wider than the operands so that A - M cannot overflow
  // when M is the most negative value.
  logic [32:0] acc_q, acc_d;
  logic [31:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [31:0] m_q, m_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic [32:0] m_ext;
  logic [32:0] booth_sum;

`ifdef MULT_DIV_DIVIDER_EN
  logic        op_div_q, op_div_d;
  logic        a_neg_q, a_neg_d;
  logic        b_neg_q, b_neg_d;
  logic [31:0] abs_a, abs_b;
  logic [32:0] rem_shift, rem_diff;
`endif

  // Booth add/subtract term selected by the {Q[0], Q-1} pair
  always_comb begin
    m_ext = {m_q[31], m_q};
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
  end

`ifdef MULT_DIV_DIVIDER_EN
  // Operand magnitudes and the restoring-division trial subtraction
  always_comb begin
    abs_a     = operand_a[31] ? (32'd0 - operand_a) : operand_a;
    abs_b     = operand_b[31] ? (32'd0 - operand_b) : operand_b;
    rem_shift = {acc_q[31:0], q_q[31]};
    rem_diff  = rem_shift - {1'b0, m_q};
  end
`endif

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
`ifdef MULT_DIV_DIVIDER_EN
    op_div_d = op_div_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          // Multiply has priority over a simultaneous divide request.
          state_d = S_RUN;
          acc_d   = 33'd0;
          q_d     = operand_b;
          qm1_d   = 1'b0;
          m_d     = operand_a;
          cnt_d   = 5'd0;
`ifdef MULT_DIV_DIVIDER_EN
          op_div_d = 1'b0;
`endif
        end else if (start_div) begin
`ifdef MULT_DIV_DIVIDER_EN
          if (operand_b == 32'd0) begin
            state_d = S_ZDIV;
          end else begin
            state_d  = S_RUN;
            acc_d    = 33'd0;
            q_d      = abs_a;
            qm1_d    = 1'b0;
            m_d      = abs_b;
            cnt_d    = 5'd0;
            op_div_d = 1'b1;
            a_neg_d  = operand_a[31];
            b_neg_d  = operand_b[31];
          end
`else
          state_d = S_ZDIV;
`endif
        end
      end
      S_RUN: begin
`ifdef MULT_DIV_DIVIDER_EN
        if (op_div_q) begin
          if (!rem_diff[32]) begin
            acc_d = rem_diff;
            q_d   = {q_q[30:0], 1'b1};
          end else begin
            acc_d = rem_shift;
            q_d   = {q_q[30:0], 1'b0};
          end
        end else begin
`else
        begin
`endif
          // Arithmetic right shift of {A, Q, Q-1}
          {acc_d, q_d, qm1_d} = {booth_sum[32], booth_sum, q_q};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIN;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef MULT_DIV_DIVIDER_EN
        if (op_div_q) begin
          lo_d = (a_neg_q ^ b_neg_q) ? (32'd0 - q_q) : q_q;
          hi_d = a_neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        end else begin
`else
        begin
`endif
          hi_d = acc_q[31:0];
          lo_d = q_q;
        end
      end
      S_ZDIV: begin
        done_d  = 1'b1;
        dz_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      acc_q   <= 33'd0;
      q_q     <= 32'd0;
      qm1_q   <= 1'b0;
      m_q     <= 32'd0;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef MULT_DIV_DIVIDER_EN
      op_div_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef MULT_DIV_DIVIDER_EN
      op_div_q <= op_div_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
`endif
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against a
// plain-arithmetic reference model. Honours MULT_DIV_DIVIDER_EN the same way
// the design does.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] operand_a, operand_b;
  logic        start_mult, start_div;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {div_zero, hi, lo} for each launched operation
  logic [64:0] exp_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .operand_a(operand_a), .operand_b(operand_b),
    .start_mult(start_mult), .start_div(start_div), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(div_zero), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns expected latency (-1 none), pushes expectation
  task automatic model_op(input bit m, input bit d, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output bit zd);
    longint p, qa, qb, qq, rr;
    zd = 1'b0;
    lat = -1;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      model_hi = p[63:32];
      model_lo = p[31:0];
      lat = 33;
    end else if (d) begin
`ifdef MULT_DIV_DIVIDER_EN
      if (b != 32'd0) begin
        qa = longint'($signed(a));
        qb = longint'($signed(b));
        qq = qa / qb;
        rr = qa % qb;
        model_lo = qq[31:0];
        model_hi = rr[31:0];
        lat = 33;
      end else begin
        zd = 1'b1;
        lat = 1;
      end
`else
      zd = 1'b1;
      lat = 1;
`endif
    end
    exp_q.push_back({zd, model_hi, model_lo});
  endtask

  // Driver: launch one op, optionally inject a glitch at cycle g_n
  // g_kind: 0 none, 1 start_div pulse, 2 reset pulse
  task automatic do_op(input string tag, input bit m, input bit d,
                       input logic [31:0] a, input logic [31:0] b,
                       input int g_n, input int g_kind);
    int exp_lat, lat, extra;
    bit zd, busy_bad, dz_at_done, dz_bad, exp_busy;
    logic [64:0] e;
    model_op(m, d, a, b, exp_lat, zd);
    if (g_kind == 2) exp_lat = -1;
    @(negedge clk);
    operand_a = a; operand_b = b; start_mult = m; start_div = d;
    @(negedge clk);                          // E0 has passed
    start_mult = 1'b0; start_div = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
    lat = -1; extra = 0; busy_bad = 0; dz_at_done = 0; dz_bad = 0;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) @(negedge clk);
      if (g_kind == 1 && n == g_n)     start_div = 1'b1;
      if (g_kind == 1 && n == g_n + 1) start_div = 1'b0;
      if (g_kind == 2 && n == g_n)     reset = 1'b0;
      if (g_kind == 2 && n == g_n + 1) reset = 1'b1;
      exp_busy = (exp_lat == 33 || g_kind == 2) && !zd && n <= 31 &&
                 !(g_kind == 2 && n > g_n);
      if (busy !== exp_busy) busy_bad = 1;
      if (done === 1'b1) begin
        if (lat < 0) begin lat = n; dz_at_done = div_zero; end
        else extra++;
      end else if (div_zero !== 1'b0) dz_bad = 1;
    end
    if (g_kind == 2) begin
      model_hi = 32'd0; model_lo = 32'd0;
      void'(exp_q.pop_back());
      exp_q.push_back({1'b0, 32'd0, 32'd0});
    end
    e = exp_q.pop_front();
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".extra_done"}, 64'(extra), 64'd0);
    check({tag, ".busy"}, 64'(busy_bad), 64'd0);
    check({tag, ".div_zero"}, {62'd0, dz_bad, dz_at_done}, {63'd0, e[64] & (lat >= 0)});
    check({tag, ".hi"}, 64'(hi), 64'(e[63:32]));
    check({tag, ".lo"}, 64'(lo), 64'(e[31:0]));
  endtask

  initial begin
    // Reset
    reset = 1'b0; start_mult = 1'b0; start_div = 1'b0;
    operand_a = 32'd0; operand_b = 32'd0;
    repeat (3) @(negedge clk);
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);
    check("reset.flags", {61'd0, busy, done, div_zero}, 64'd0);
    reset = 1'b1;

    // Directed cases
    do_op("mul_7_m3",   1, 0, 32'h00000007, 32'hFFFFFFFD, 0, 0);
    do_op("mul_min_min",1, 0, 32'h80000000, 32'h80000000, 0, 0);
    do_op("div_m7_2",   0, 1, 32'hFFFFFFF9, 32'h00000002, 0, 0);
    do_op("div_min_m1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    do_op("mul_set12",  1, 0, 32'h00000006, 32'h2AAAAAAB, 0, 0);
    do_op("div_5_0",    0, 1, 32'h00000005, 32'h00000000, 0, 0);
    do_op("div_5_3",    0, 1, 32'h00000005, 32'h00000003, 0, 0);
    do_op("mul_abort",  1, 0, 32'h12345678, 32'h9ABCDEF0, 9, 2);
    do_op("mul_ign_div",1, 0, 32'hFFFF0001, 32'h00010003, 4, 1);
    do_op("both_start", 1, 1, 32'hFFFFFFFF, 32'h00000009, 0, 0);

    // Random cases
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      bit is_m;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9)) ^ {32{ra[0]}};
      is_m = $urandom_range(0, 1) == 1;
      do_op(is_m ? "rnd_mul" : "rnd_div", is_m, !is_m, ra, rb, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
